// File: rtl/jtvigil_mix_pkg.sv
// Shared constants and helpers for the jtvigil layer mixer / palette engine.
package jtvigil_mix_pkg;

    localparam int unsigned CH_R = 0;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 2;

    // A pixel is high priority when its two top bits are set together with this bit
    localparam int unsigned HP_BIT = 3;
    localparam logic [1:0]  HP_TOP = 2'b11;

    function automatic int unsigned calc_lw(input int unsigned nl);
        return (nl <= 2) ? 1 : $clog2(nl);
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port synchronous RAM with registered read ports and read-old-data on collisions.
module jtframe_dual_ram #(
    parameter int unsigned dw = 8,
    parameter int unsigned aw = 10
) (
    input  logic          clk0,
    input  logic [dw-1:0] data0,
    input  logic [aw-1:0] addr0,
    input  logic          we0,
    output logic [dw-1:0] q0,
    input  logic          clk1,
    input  logic [dw-1:0] data1,
    input  logic [aw-1:0] addr1,
    input  logic          we1,
    output logic [dw-1:0] q1
);

    logic [dw-1:0] mem [0:2**aw-1];

    // Both write ports live in one process so the array keeps a single driver
    always_ff @(posedge clk0) begin
        q0 <= mem[addr0];
        if (we0) mem[addr0] <= data0;
        if (we1) mem[addr1] <= data1;
    end

    always_ff @(posedge clk1) begin
        q1 <= mem[addr1];
    end

endmodule

// File: rtl/jtvigil_prio_sel.sv
// Combinational winner selection across NL layers: highest hp layer, else highest
// opaque layer, else the raw backdrop pixel of layer 0.
module jtvigil_prio_sel
    import jtvigil_mix_pkg::*;
#(
    parameter  int unsigned NL = 3,
    parameter  int unsigned PW = 8,
    localparam int unsigned LW = calc_lw(NL)
) (
    input  logic [NL*PW-1:0] layer_pxl,
    input  logic [NL-1:0]    layer_en,
    output logic [LW-1:0]    win_bank,
    output logic [PW-1:0]    win_idx
);

    always_comb begin
        logic [PW-1:0] pxl;
        logic          opaque;
        logic          hp;
        logic          hp_found;
        win_bank = '0;
        win_idx  = layer_pxl[PW-1:0];
        pxl      = '0;
        opaque   = 1'b0;
        hp       = 1'b0;
        hp_found = 1'b0;
        // Ascending scan: a later layer overrides, but nothing below hp overrides an hp pick
        for (int i = 0; i < NL; i++) begin
            pxl    = layer_pxl[i*PW +: PW];
            opaque = (pxl[3:0] != 4'd0) && layer_en[i];
            hp     = opaque && (pxl[PW-1 -: 2] == HP_TOP) && pxl[HP_BIT];
            if (hp) begin
                win_bank = LW'(i);
                win_idx  = pxl;
                hp_found = 1'b1;
            end else if (opaque && !hp_found) begin
                win_bank = LW'(i);
                win_idx  = pxl;
            end
        end
    end

endmodule

// File: rtl/jtvigil_prio_mix.sv
// N-layer priority mixer: latches the winning pixel at pxl_cen, fetches R/G/B from the
// palette over the following 8 clocks and outputs the brightness-scaled colour next pxl_cen.
module jtvigil_prio_mix
    import jtvigil_mix_pkg::*;
#(
    parameter  int unsigned NL = 3,
    parameter  int unsigned PW = 8,
    parameter  int unsigned CW = 5,
    localparam int unsigned LW = calc_lw(NL),
    localparam int unsigned AW = LW + 2 + PW
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             pxl_cen,
    input  logic             LHBL,
    input  logic             LVBL,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [7:0]       cpu_dout,
    output logic [7:0]       cpu_din,
    input  logic             pal_cs,
    input  logic             cpu_rnw,
    input  logic [NL*PW-1:0] layer_pxl,
    input  logic [NL-1:0]    layer_en,
    input  logic [3:0]       bright,
    output logic [CW-1:0]    red,
    output logic [CW-1:0]    green,
    output logic [CW-1:0]    blue
);

    logic [LW-1:0] win_bank_c, win_bank;
    logic [PW-1:0] win_idx_c, win_idx;
    logic [2:0]    sub;
    logic [CW-1:0] pre_r, pre_g, pre_b;
    logic [CW-1:0] pal_q, cpu_q, din_hold;
    logic [AW-1:0] vid_addr;
    logic          cpu_we, rd_q, blank;
    logic          unused_dout;

    function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [3:0] b);
        logic [CW+4:0] prod;
        prod = (CW+5)'(c) * ((CW+5)'(b) + (CW+5)'(1));
        return prod[CW+3:4];
    endfunction

    assign cpu_we      = pal_cs && !cpu_rnw;
    assign vid_addr    = {win_bank, sub[2:1], win_idx};
    assign blank       = !LHBL || !LVBL;
    assign unused_dout = ^cpu_dout;

    jtvigil_prio_sel #(
        .NL (NL),
        .PW (PW)
    ) u_sel (
        .layer_pxl (layer_pxl),
        .layer_en  (layer_en),
        .win_bank  (win_bank_c),
        .win_idx   (win_idx_c)
    );

    jtframe_dual_ram #(
        .dw (CW),
        .aw (AW)
    ) u_ram (
        .clk0  (clk),
        .data0 (cpu_dout[CW-1:0]),
        .addr0 (cpu_addr),
        .we0   (cpu_we),
        .q0    (cpu_q),
        .clk1  (clk),
        .data1 ('0),
        .addr1 (vid_addr),
        .we1   (1'b0),
        .q1    (pal_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_bank <= '0;
            win_idx  <= '0;
            sub      <= '0;
            pre_r    <= '0;
            pre_g    <= '0;
            pre_b    <= '0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else begin
            if (pxl_cen) begin
                win_bank <= win_bank_c;
                win_idx  <= win_idx_c;
                sub      <= '0;
                red      <= blank ? '0 : scale(pre_r, bright);
                green    <= blank ? '0 : scale(pre_g, bright);
                blue     <= blank ? '0 : scale(pre_b, bright);
            end else if (sub != 3'd7) begin
                sub <= sub + 3'd1;
            end
            // Odd steps see the RAM output for the address presented on the even step
            if (sub[0]) begin
                case (sub[2:1])
                    2'(CH_R): pre_r <= pal_q;
                    2'(CH_G): pre_g <= pal_q;
                    2'(CH_B): pre_b <= pal_q;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q     <= 1'b0;
            din_hold <= '0;
        end else begin
            rd_q <= pal_cs && cpu_rnw;
            if (rd_q) din_hold <= cpu_q;
        end
    end

    // Show the RAM output the clock after a read, then hold it until the next read
    assign cpu_din = rd_q ? 8'(cpu_q) : 8'(din_hold);

endmodule
